// File: rtl/sin_pkg.sv
// -----------------------------------------------------------------------------
// sin_pkg
// Shared types and constants for the single-wire s_in link: the serializer FSM
// state encoding and the default idle level of the line. The idle level is
// shared by the serializer, the serial detector and the benches.
// -----------------------------------------------------------------------------
package sin_pkg;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_SHIFT,
      SER_GAP
   } ser_state_e;

   localparam logic SIN_IDLE_LEVEL_DEFAULT = 1'b0;

endpackage : sin_pkg

// File: rtl/sin_serializer.sv
// -----------------------------------------------------------------------------
// sin_serializer
// Parallel-in, serial-out transmitter for the single-wire s_in link. A WIDTH-bit
// word is taken on a valid/ready handshake and shifted out one bit per clk,
// MSB or LSB first. GAP idle cycles can be forced between words.
//
// Ports
//   clk        in   1      single clock, all logic on posedge
//   rst_n      in   1      synchronous active-low reset
//   in_data    in   WIDTH  word to transmit
//   in_valid   in   1      in_data valid
//   in_ready   out  1      a word can be accepted this cycle
//   s_out      out  1      serial data (drives the detector's s_in)
//   bit_valid  out  1      s_out carries a data bit this cycle
//   word_done  out  1      pulse: the last bit of a word is on s_out
// -----------------------------------------------------------------------------
module sin_serializer
   import sin_pkg::*;
#(
   parameter int   WIDTH      = 8,
   parameter int   LSB_FIRST  = 0,
   parameter int   GAP        = 0,
   parameter logic IDLE_LEVEL = SIN_IDLE_LEVEL_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             s_out,
   output logic             bit_valid,
   output logic             word_done
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] BIT_PENULT = CNT_W'(WIDTH - 2);
   localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   ser_state_e       state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             s_out_q, s_out_d;
   logic             bit_valid_q, bit_valid_d;
   logic             word_done_q, word_done_d;

   logic [WIDTH-1:0] shifted;
   logic             accept;

   // Bit that goes on the line first for a freshly loaded word.
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
   endfunction

   // Ready depends only on state and counters, so upstream may wait on it
   // before raising in_valid without forming a combinational loop.
   always_comb begin
      in_ready = 1'b0;
      if (rst_n) begin
         case (state_q)
            SER_IDLE:  in_ready = 1'b1;
            // With no gap, the last-bit cycle reloads so words run back to back.
            SER_SHIFT: in_ready = (GAP == 0) && (bit_cnt_q == BIT_LAST);
            default:   in_ready = 1'b0;
         endcase
      end
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      s_out_d     = IDLE_LEVEL;
      bit_valid_d = 1'b0;
      word_done_d = 1'b0;
      shifted     = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);

      case (state_q)
         SER_IDLE: begin
            if (accept) begin
               state_d     = SER_SHIFT;
               shift_d     = in_data;
               bit_cnt_d   = '0;
               s_out_d     = first_bit(in_data);
               bit_valid_d = 1'b1;
            end
         end

         SER_SHIFT: begin
            if (bit_cnt_q != BIT_LAST) begin
               shift_d     = shifted;
               bit_cnt_d   = bit_cnt_q + CNT_W'(1);
               s_out_d     = (LSB_FIRST != 0) ? shifted[0] : shifted[WIDTH-1];
               bit_valid_d = 1'b1;
               // Registered pulse lines up with the last bit reaching s_out.
               word_done_d = (bit_cnt_q == BIT_PENULT);
            end else if (GAP > 0) begin
               state_d   = SER_GAP;
               bit_cnt_d = '0;
               gap_cnt_d = '0;
            end else if (accept) begin
               shift_d     = in_data;
               bit_cnt_d   = '0;
               s_out_d     = first_bit(in_data);
               bit_valid_d = 1'b1;
            end else begin
               state_d   = SER_IDLE;
               bit_cnt_d = '0;
            end
         end

         SER_GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d   = SER_IDLE;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end

         default: begin
            state_d   = SER_IDLE;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q     <= SER_IDLE;
         // NOTE: the shift register is cleared too; it is one word wide and a
         // known value keeps X out of s_out after an aborted word.
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         s_out_q     <= IDLE_LEVEL;
         bit_valid_q <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         s_out_q     <= s_out_d;
         bit_valid_q <= bit_valid_d;
         word_done_q <= word_done_d;
      end
   end

   assign s_out     = s_out_q;
   assign bit_valid = bit_valid_q;
   assign word_done = word_done_q;

endmodule : sin_serializer

// File: tb/tb_sin_serializer.sv
// -----------------------------------------------------------------------------
// tb_sin_serializer
// Directed bench for sin_serializer. Three instances share clk/rst_n:
//   u_dut0  WIDTH=8, MSB first, GAP=0
//   u_dut1  WIDTH=8, MSB first, GAP=3
//   u_dut2  WIDTH=8, LSB first, GAP=0
// Expected bits are pushed to a per-instance queue when a word is handed over
// and popped whenever that instance shows bit_valid.
// -----------------------------------------------------------------------------
module tb_sin_serializer;
   import sin_pkg::*;

   localparam int W = 8;

   typedef struct packed {
      logic b;
      logic done;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0][W-1:0] in_data;
   logic [2:0]        in_valid;
   logic [2:0]        in_ready;
   logic [2:0]        s_out;
   logic [2:0]        bit_valid;
   logic [2:0]        word_done;

   sin_serializer #(.WIDTH(W), .LSB_FIRST(0), .GAP(0), .IDLE_LEVEL(SIN_IDLE_LEVEL_DEFAULT)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .s_out(s_out[0]), .bit_valid(bit_valid[0]), .word_done(word_done[0]));

   sin_serializer #(.WIDTH(W), .LSB_FIRST(0), .GAP(3), .IDLE_LEVEL(SIN_IDLE_LEVEL_DEFAULT)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .s_out(s_out[1]), .bit_valid(bit_valid[1]), .word_done(word_done[1]));

   sin_serializer #(.WIDTH(W), .LSB_FIRST(1), .GAP(0), .IDLE_LEVEL(SIN_IDLE_LEVEL_DEFAULT)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
      .in_ready(in_ready[2]), .s_out(s_out[2]), .bit_valid(bit_valid[2]), .word_done(word_done[2]));

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int checks = 0;
   int errors = 0;
   int run_len [3];
   int max_run [3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int q_size(input int idx);
      case (idx)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic push_word(input int idx, input logic [W-1:0] w, input bit lsb);
      exp_t e;
      for (int i = 0; i < W; i++) begin
         e.b    = lsb ? w[i] : w[W-1-i];
         e.done = (i == W - 1);
         case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
         endcase
      end
   endtask

   task automatic pop_exp(input int idx, output exp_t e);
      case (idx)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
   endtask

   task automatic flush(input int idx);
      case (idx)
         0:       q0.delete();
         1:       q1.delete();
         default: q2.delete();
      endcase
   endtask

   task automatic monitor(input int idx, input logic rst_at_edge);
      exp_t e;
      if (!rst_at_edge) begin
         check($sformatf("dut%0d reset s_out", idx), s_out[idx], SIN_IDLE_LEVEL_DEFAULT);
         check($sformatf("dut%0d reset bit_valid", idx), bit_valid[idx], 0);
         check($sformatf("dut%0d reset word_done", idx), word_done[idx], 0);
      end else if (bit_valid[idx] === 1'b1) begin
         if (q_size(idx) == 0) begin
            check($sformatf("dut%0d unexpected bit", idx), bit_valid[idx], 0);
         end else begin
            pop_exp(idx, e);
            check($sformatf("dut%0d s_out bit", idx), s_out[idx], e.b);
            check($sformatf("dut%0d word_done", idx), word_done[idx], e.done);
         end
      end else begin
         check($sformatf("dut%0d idle s_out", idx), s_out[idx], SIN_IDLE_LEVEL_DEFAULT);
         check($sformatf("dut%0d idle word_done", idx), word_done[idx], 0);
      end
      if (!rst_n) check($sformatf("dut%0d in_ready in reset", idx), in_ready[idx], 0);
      if (bit_valid[idx] === 1'b1) begin
         run_len[idx]++;
         if (run_len[idx] > max_run[idx]) max_run[idx] = run_len[idx];
      end else begin
         run_len[idx] = 0;
      end
   endtask

   // One clock: outputs are sampled 1 time unit after the edge.
   task automatic step();
      logic rs;
      rs = rst_n;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) monitor(i, rs);
   endtask

   task automatic wait_ready(input int idx, input int budget);
      int n;
      n = 0;
      while (in_ready[idx] !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      check($sformatf("dut%0d wait in_ready", idx), in_ready[idx], 1);
   endtask

   task automatic send(input int idx, input logic [W-1:0] w, input bit lsb);
      in_data[idx]  = w;
      in_valid[idx] = 1'b1;
      wait_ready(idx, 40);
      push_word(idx, w, lsb);
      step();
      in_valid[idx] = 1'b0;
      in_data[idx]  = 'x;
   endtask

   task automatic drain(input int idx);
      int n;
      n = 0;
      while (q_size(idx) != 0 && n < 40) begin
         step();
         n++;
      end
      check($sformatf("dut%0d drain", idx), q_size(idx), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int gap;
      for (int i = 0; i < 3; i++) begin
         run_len[i] = 0;
         max_run[i] = 0;
      end

      // Reset held 3 cycles with in_valid high: everything stays quiet.
      in_data  = {3{8'hFF}};
      in_valid = 3'b111;
      rst_n    = 1'b0;
      repeat (3) step();
      in_valid = 3'b000;
      in_data  = 'x;
      rst_n    = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("dut%0d ready after reset", i), in_ready[i], 1);
         check($sformatf("dut%0d bit_valid after reset", i), bit_valid[i], 0);
      end

      // Single MSB-first word 8'hB4 -> 1,0,1,1,0,1,0,0.
      send(0, 8'hB4, 1'b0);
      drain(0);
      step();
      check("single idle bit_valid", bit_valid[0], 0);
      check("single idle in_ready", in_ready[0], 1);
      check("single idle s_out", s_out[0], 0);

      // Back-to-back FF then 00 with in_valid held: 16 contiguous bits.
      run_len[0]    = 0;
      max_run[0]    = 0;
      in_data[0]    = 8'hFF;
      in_valid[0]   = 1'b1;
      wait_ready(0, 40);
      push_word(0, 8'hFF, 1'b0);
      step();
      in_data[0] = 8'h00;
      wait_ready(0, 40);
      push_word(0, 8'h00, 1'b0);
      step();
      in_valid[0] = 1'b0;
      in_data[0]  = 'x;
      drain(0);
      check("b2b contiguous bits", max_run[0], 16);

      // GAP=3: A5 then 5A with in_valid held during the gap.
      in_data[1]  = 8'hA5;
      in_valid[1] = 1'b1;
      wait_ready(1, 40);
      push_word(1, 8'hA5, 1'b0);
      step();
      in_data[1] = 8'h5A;
      n = 0;
      while (word_done[1] !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("gap first word_done", word_done[1], 1);
      gap = 0;
      step();
      while (bit_valid[1] === 1'b0 && in_ready[1] === 1'b0 && gap < 20) begin
         gap++;
         step();
      end
      check("gap forced idle cycles", gap, 3);
      // The gap is followed by one IDLE cycle in which the pending word is taken.
      check("gap end in_ready", in_ready[1], 1);
      check("gap end bit_valid", bit_valid[1], 0);
      push_word(1, 8'h5A, 1'b0);
      step();
      in_valid[1] = 1'b0;
      in_data[1]  = 'x;
      drain(1);

      // LSB-first 8'h01 -> 1 then seven 0s.
      send(2, 8'h01, 1'b1);
      drain(2);

      // Reset at bit 4 of C3 aborts the word; 81 then goes out intact.
      send(0, 8'hC3, 1'b0);
      repeat (4) step();
      rst_n = 1'b0;
      flush(0);
      step();
      rst_n = 1'b1;
      step();
      check("abort idle bit_valid", bit_valid[0], 0);
      check("abort idle in_ready", in_ready[0], 1);
      send(0, 8'h81, 1'b0);
      drain(0);
      step();

      for (int i = 0; i < 3; i++)
         check($sformatf("dut%0d queue empty at end", i), q_size(i), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_sin_serializer
